// File: rtl/expr_pkg.sv
// -----------------------------------------------------------------------------
// expr_pkg
//   Shared definitions for the infix expression evaluator:
//     - token codes (operand values 0-15 share the code space with operators)
//     - FSM state enum and datapath control enums
//     - operator precedence and the "reduce before pushing" decision
//     - default stack depth
// -----------------------------------------------------------------------------
package expr_pkg;

  localparam int DEFAULT_DEPTH = 8;

  // Codes 0-15 are operand values; operators sit directly above them.
  typedef logic [4:0] tok_t;

  localparam tok_t TOK_LPAREN = 5'd16;
  localparam tok_t TOK_RPAREN = 5'd17;
  localparam tok_t TOK_STAR   = 5'd18;
  localparam tok_t TOK_PLUS   = 5'd19;
  localparam tok_t TOK_MINUS  = 5'd20;
  localparam tok_t TOK_EQ     = 5'd21;

  typedef enum logic [1:0] {
    ST_ACCEPT,
    ST_REDUCE,
    ST_FINISH,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    OPND_NONE,
    OPND_PUSH,
    OPND_REDUCE,  // pop b and a, push a op b: net depth change of -1
    OPND_CLEAR
  } opnd_op_e;

  typedef enum logic [1:0] {
    OPER_NONE,
    OPER_PUSH,
    OPER_POP,
    OPER_CLEAR
  } oper_op_e;

  // Binding strength of an operator; '(' and ')' are 0 so they never reduce.
  function automatic logic [1:0] prec(input tok_t t);
    case (t)
      TOK_STAR:            return 2'd2;
      TOK_PLUS, TOK_MINUS: return 2'd1;
      default:             return 2'd0;
    endcase
  endfunction

  // True when the operator on top of the stack must be evaluated before the
  // incoming operator may proceed. ')' drains everything down to its '('.
  function automatic logic must_reduce(input tok_t incoming, input tok_t top);
    if (incoming == TOK_RPAREN) return top != TOK_LPAREN;
    return (prec(top) != 2'd0) && (prec(top) >= prec(incoming));
  endfunction

endpackage

// File: rtl/ascii_to_decimal.sv
// -----------------------------------------------------------------------------
// ascii_to_decimal
//   Combinational hex-digit decoder: '0'-'9' -> 0-9, 'a'-'f' -> 10-15.
//   Every other code decodes to 0, so callers that need to tell a real '0'
//   from garbage must check legality themselves.
//
//   Ports
//     ascii_i  [7:0]  character code
//     value_o  [3:0]  decoded value
// -----------------------------------------------------------------------------
module ascii_to_decimal (
  input  logic [7:0] ascii_i,
  output logic [3:0] value_o
);

  always_comb begin
    value_o = 4'd0;
    if (ascii_i >= 8'h30 && ascii_i <= 8'h39) begin
      value_o = 4'(ascii_i - 8'h30);
    end else if (ascii_i >= 8'h61 && ascii_i <= 8'h66) begin
      value_o = 4'(ascii_i - 8'h57);
    end
  end

endmodule

// File: rtl/expr_eval_ctrl.sv
// -----------------------------------------------------------------------------
// expr_eval_ctrl
//   Streaming infix expression evaluator (two-stack shunting-yard).
//   Characters arrive one per handshake; '=' terminates the expression and
//   produces a one-cycle result pulse. Errors are sticky until that pulse.
//
//   Parameters
//     DATA_W  operand / result width
//     DEPTH   entries in each of the operand and operator stacks
//
//   Ports
//     clk           clock, all state on the rising edge
//     rst           asynchronous active-high reset
//     ascii_in      expression character
//     in_valid      ascii_in holds a character
//     in_ready      character accepted this cycle (ACCEPT state only)
//     result        evaluated value, held between pulses
//     result_valid  one-cycle pulse with the final value
//     err           sticky fault flag for the current expression
// -----------------------------------------------------------------------------
module expr_eval_ctrl
  import expr_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        ascii_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              err
);

  localparam int              SP_W    = $clog2(DEPTH + 1);
  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);
  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
  localparam logic [SP_W-1:0] SP_TWO  = SP_W'(2);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;

  logic [DATA_W-1:0] opnd_mem [DEPTH];
  tok_t              oper_mem [DEPTH];
  logic [SP_W-1:0]   opnd_sp_q;
  logic [SP_W-1:0]   oper_sp_q;
  tok_t              pending_q;     // operator waiting for REDUCE to finish
  logic [DATA_W-1:0] result_q;
  logic              err_q;

  // ---------------------------------------------------------------------------
  // Character decode. The hex decoder maps illegal codes to 0, so legality is
  // decided here independently of its output.
  // ---------------------------------------------------------------------------
  logic [3:0] dec_value;
  logic       is_operand;
  logic       illegal;
  tok_t       tok;

  ascii_to_decimal u_dec (
    .ascii_i (ascii_in),
    .value_o (dec_value)
  );

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first; a path that skips an assignment would otherwise infer a latch.
    is_operand = ((ascii_in >= 8'h30) && (ascii_in <= 8'h39)) ||
                 ((ascii_in >= 8'h61) && (ascii_in <= 8'h66));
    illegal    = 1'b0;
    tok        = {1'b0, dec_value};
    if (!is_operand) begin
      case (ascii_in)
        8'h28:   tok = TOK_LPAREN;  // '('
        8'h29:   tok = TOK_RPAREN;  // ')'
        8'h2A:   tok = TOK_STAR;    // '*'
        8'h2B:   tok = TOK_PLUS;    // '+'
        8'h2D:   tok = TOK_MINUS;   // '-'
        8'h3D:   tok = TOK_EQ;      // '='
        default: illegal = 1'b1;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stack views
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]  opnd_push_idx, opnd_b_idx, opnd_a_idx;
  logic [IDX_W-1:0]  oper_push_idx, oper_top_idx;
  logic [DATA_W-1:0] opnd_a, opnd_b;
  tok_t              oper_top;
  logic              opnd_empty, opnd_full, opnd_lt2;
  logic              oper_empty, oper_full;

  assign opnd_push_idx = IDX_W'(opnd_sp_q);
  assign opnd_b_idx    = IDX_W'(opnd_sp_q - SP_ONE);
  assign opnd_a_idx    = IDX_W'(opnd_sp_q - SP_TWO);
  assign oper_push_idx = IDX_W'(oper_sp_q);
  assign oper_top_idx  = IDX_W'(oper_sp_q - SP_ONE);

  // Tops are read unconditionally; every consumer is gated by the
  // empty / depth flags, so a stale read on an empty stack is harmless.
  assign opnd_b     = opnd_mem[opnd_b_idx];
  assign opnd_a     = opnd_mem[opnd_a_idx];
  assign oper_top   = oper_mem[oper_top_idx];

  assign opnd_empty = (opnd_sp_q == '0);
  assign opnd_full  = (opnd_sp_q >= SP_FULL);
  assign opnd_lt2   = (opnd_sp_q < SP_TWO);
  assign oper_empty = (oper_sp_q == '0);
  assign oper_full  = (oper_sp_q >= SP_FULL);

  logic accept;
  logic tok_is_binop;
  logic in_hit;     // incoming operator must wait for a reduction
  logic pend_hit;   // registered operator still has to wait

  assign accept       = in_valid && in_ready;
  assign tok_is_binop = tok inside {TOK_STAR, TOK_PLUS, TOK_MINUS};
  assign in_hit       = !oper_empty && must_reduce(tok, oper_top);
  assign pend_hit     = !oper_empty && must_reduce(pending_q, oper_top);

  // ---------------------------------------------------------------------------
  // Reduction ALU: a op b with b on top; results wrap modulo 2^DATA_W.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] alu_res;

  always_comb begin
    case (oper_top)
      TOK_STAR:  alu_res = opnd_a * opnd_b;
      TOK_PLUS:  alu_res = opnd_a + opnd_b;
      TOK_MINUS: alu_res = opnd_a - opnd_b;
      default:   alu_res = opnd_a;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state_q <= ST_ACCEPT;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCEPT: begin
        if (accept && !illegal) begin
          if (tok == TOK_EQ) begin
            // With nothing pending there is nothing to finish; going straight
            // to DONE keeps the result latency at (pending operators + 1).
            state_d = oper_empty ? ST_DONE : ST_FINISH;
          end else if ((tok_is_binop || tok == TOK_RPAREN) && in_hit) begin
            state_d = ST_REDUCE;
          end
        end
      end
      ST_REDUCE: if (!pend_hit) state_d = ST_ACCEPT;
      // The last operator is consumed in the same cycle DONE is selected.
      ST_FINISH: if (oper_sp_q <= SP_ONE) state_d = ST_DONE;
      ST_DONE:   state_d = ST_ACCEPT;
      default:   state_d = ST_ACCEPT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath control
  // ---------------------------------------------------------------------------
  opnd_op_e opnd_op;
  oper_op_e oper_op;
  tok_t     oper_push_tok;
  logic     pending_load;
  logic     reduce_req;
  logic     err_set;

  always_comb begin
    opnd_op       = OPND_NONE;
    oper_op       = OPER_NONE;
    oper_push_tok = tok;
    pending_load  = 1'b0;
    reduce_req    = 1'b0;
    err_set       = 1'b0;

    case (state_q)
      ST_ACCEPT: begin
        if (accept) begin
          if (illegal) begin
            err_set = 1'b1;
          end else if (is_operand) begin
            if (opnd_full) err_set = 1'b1;
            else           opnd_op = OPND_PUSH;
          end else begin
            case (tok)
              TOK_LPAREN: begin
                if (oper_full) err_set = 1'b1;
                else           oper_op = OPER_PUSH;
              end
              TOK_RPAREN: begin
                if (oper_empty)  err_set      = 1'b1;
                else if (in_hit) pending_load = 1'b1;
                else             oper_op      = OPER_POP;  // matching '('
              end
              TOK_STAR, TOK_PLUS, TOK_MINUS: begin
                if (in_hit)         pending_load = 1'b1;
                else if (oper_full) err_set      = 1'b1;
                else                oper_op      = OPER_PUSH;
              end
              default: ;  // '=' only moves the FSM
            endcase
          end
        end
      end

      ST_REDUCE: begin
        if (pend_hit) begin
          reduce_req = 1'b1;
        end else if (pending_q == TOK_RPAREN) begin
          // Either the matching '(' is on top, or the stack ran dry.
          if (oper_empty) err_set = 1'b1;
          else            oper_op = OPER_POP;
        end else begin
          oper_push_tok = pending_q;
          if (oper_full) err_set = 1'b1;
          else           oper_op = OPER_PUSH;
        end
      end

      ST_FINISH: begin
        if (!oper_empty) begin
          if (oper_top == TOK_LPAREN) begin
            err_set = 1'b1;           // unmatched '(' is discarded
            oper_op = OPER_POP;
          end else begin
            reduce_req = 1'b1;
          end
        end
      end

      ST_DONE: begin
        opnd_op = OPND_CLEAR;
        oper_op = OPER_CLEAR;
      end

      default: ;
    endcase

    // The operator is always popped so a short operand stack cannot stall
    // the FSM; only the operand update is skipped.
    if (reduce_req) begin
      oper_op = OPER_POP;
      if (opnd_lt2) err_set = 1'b1;
      else          opnd_op = OPND_REDUCE;
    end
  end

  logic [DATA_W-1:0] done_value;

  assign done_value   = opnd_empty ? '0 : opnd_b;
  assign in_ready     = (state_q == ST_ACCEPT) && !rst;
  assign result_valid = (state_q == ST_DONE);
  assign result       = result_valid ? done_value : result_q;
  assign err          = err_q;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opnd_sp_q <= '0;
      oper_sp_q <= '0;
      pending_q <= TOK_PLUS;
      result_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      case (opnd_op)
        OPND_PUSH:   opnd_sp_q <= opnd_sp_q + SP_ONE;
        OPND_REDUCE: opnd_sp_q <= opnd_sp_q - SP_ONE;
        OPND_CLEAR:  opnd_sp_q <= '0;
        default:     ;
      endcase

      case (oper_op)
        OPER_PUSH:  oper_sp_q <= oper_sp_q + SP_ONE;
        OPER_POP:   oper_sp_q <= oper_sp_q - SP_ONE;
        OPER_CLEAR: oper_sp_q <= '0;
        default:    ;
      endcase

      if (pending_load) pending_q <= tok;

      if (state_q == ST_DONE) begin
        result_q <= done_value;
        err_q    <= 1'b0;
      end else if (err_set) begin
        err_q    <= 1'b1;
      end
    end
  end

  // NOTE: stack storage has no reset; the pointers alone define which
  // entries are live, so clearing the arrays would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (opnd_op == OPND_PUSH) begin
      opnd_mem[opnd_push_idx] <= DATA_W'(dec_value);
    end else if (opnd_op == OPND_REDUCE) begin
      opnd_mem[opnd_a_idx] <= alu_res;
    end
    if (oper_op == OPER_PUSH) begin
      oper_mem[oper_push_idx] <= oper_push_tok;
    end
  end

endmodule

// File: tb/tb_expr_eval_ctrl.sv
// -----------------------------------------------------------------------------
// tb_expr_eval_ctrl
//   Directed bench for expr_eval_ctrl. Expected results are queued when '='
//   is sent and compared by a monitor when result_valid pulses.
// -----------------------------------------------------------------------------
module tb_expr_eval_ctrl;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        ascii_in = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              err;

  expr_eval_ctrl #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ascii_in     (ascii_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .result       (result),
    .result_valid (result_valid),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] res;
    logic              err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Scoreboard consumer: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && result_valid === 1'b1) begin
      check("pulse_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("result", result, mon_e.res);
        check("err_at_result", 32'(err), 32'(mon_e.err));
      end
    end
  end

  // Drive one character and hold it until accepted; returns on a negedge.
  task automatic send(input logic [7:0] c);
    int n = 0;
    ascii_in = c;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  // '=' with its expectation; n_ops operators are pending when '=' lands.
  task automatic send_eq(input logic [DATA_W-1:0] want, input logic want_err, input int n_ops);
    int lat;
    sb.push_back('{want, want_err});
    send(8'h3D);
    lat = 1;
    while (result_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(n_ops + 1));
    @(negedge clk);
    check("pulse_one_cycle", 32'(result_valid), 32'd0);
    check("result_hold", result, want);
    check("err_cleared", 32'(err), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  // '*' expected to start a reduction: controller must stall the next cycle.
  task automatic send_star_reduce();
    send(8'h2A);
    check("ready_low_in_reduce", 32'(in_ready), 32'd0);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    #1 check("ready_after_release", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Precedence: 3+4*2 = 11
    send_str("3+4*2");
    send_eq(32'd11, 1'b0, 2);

    // Parentheses drive a REDUCE run ending on '('.
    send_str("(3+4");
    send(8'h29);
    check("ready_low_rparen", 32'(in_ready), 32'd0);
    send_str("*2");
    send_eq(32'd14, 1'b0, 1);

    // Wrap-around subtraction: 10 - 15
    send_str("a-f");
    send_eq(32'hFFFF_FFFB, 1'b0, 1);

    // Left associativity: 8-3-2 = 3
    send_str("8-3-2");
    send_eq(32'd3, 1'b0, 1);

    // Chained multiply: 15^8
    send_str("f*");
    check("ready_after_first_star", 32'(in_ready), 32'd1);
    send(8'h66);
    for (int i = 0; i < 6; i++) begin
      send_star_reduce();
      send(8'h66);
    end
    send_eq(32'd2562890625, 1'b0, 1);

    // Operator stack overflow and unmatched ')'
    for (int i = 0; i < 8; i++) send(8'h28);
    check("err_clear_at_depth", 32'(err), 32'd0);
    send(8'h28);
    check("err_on_overflow", 32'(err), 32'd1);
    send(8'h31);
    for (int i = 0; i < 9; i++) send(8'h29);
    send_eq(32'd1, 1'b1, 0);

    // Illegal character is consumed, expression still completes.
    send_str("3#+1");
    check("err_on_illegal", 32'(err), 32'd1);
    send_eq(32'd4, 1'b1, 1);

    // Reduction with no operands; empty operand stack yields 0.
    send(8'h2B);
    send_eq(32'd0, 1'b1, 1);

    // '(' left over at FINISH is dropped with err.
    send_str("(5");
    send_eq(32'd5, 1'b1, 1);

    // Reset mid-expression discards partial state.
    send_str("5+");
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_valid", 32'(result_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("midrst_ready_after", 32'(in_ready), 32'd1);
    @(negedge clk);
    send(8'h32);
    send_eq(32'd2, 1'b0, 0);

    repeat (3) @(negedge clk);
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation did not complete");
  end

endmodule

// File: doc/expr_eval_ctrl.md
EXPR_EVAL_CTRL -- requirements
Module: expr_eval_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning operand/result width.
REQ-002 SHALL have parameter DEPTH, default 8, meaning entries per stack, operand and operator.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset; asynchronous, active-high.
REQ-005 SHALL have port ascii_in, input, 8, meaning one expression character.
REQ-006 SHALL have port in_valid, input, 1, meaning ascii_in holds a character.
REQ-007 SHALL have port in_ready, output, 1, meaning the controller accepts ascii_in this cycle.
REQ-008 SHALL have port result, output, DATA_W, meaning the evaluated value, two's complement.
REQ-009 SHALL have port result_valid, output, 1, meaning result is valid; one-cycle pulse.
REQ-010 SHALL have port err, output, 1, meaning a sticky fault flag for the current expression.

Function
REQ-011 SHALL accept a character only when in_valid && in_ready on a rising edge.
REQ-012 SHALL decode characters into tokens:
- '0'-'9' and 'a'-'f' are single-character operands 0-15.
- '(' ')' '*' '+' '-' '=' are operators.
- Any other code is consumed with no stack effect and sets err.
REQ-013 SHALL have states ACCEPT, REDUCE, FINISH and DONE; in_ready=1 only in ACCEPT.
REQ-014 In ACCEPT, an operand SHALL be zero-extended to DATA_W and pushed to the operand stack.
REQ-015 In ACCEPT, '(' SHALL be pushed to the operator stack.
REQ-016 Incoming '+' or '-' SHALL enter REDUCE while the operator top is '*', '+' or '-'; otherwise it is pushed.
REQ-017 Incoming '*' SHALL enter REDUCE while the operator top is '*'; otherwise it is pushed.
REQ-018 Incoming ')' SHALL enter REDUCE until the top is '(', then pop the '(' in the same cycle as the last check.
REQ-019 Incoming '=' SHALL enter FINISH.
REQ-020 REDUCE and FINISH SHALL perform exactly one reduction per cycle:
- pop operands b (top) and a, and pop operator op;
- push a op b, truncated modulo 2^DATA_W.
REQ-021 The pending operator in REDUCE SHALL be registered and pushed on the cycle the reduce condition becomes false, returning to ACCEPT.
REQ-022 FINISH SHALL reduce until the operator stack is empty, then go to DONE.
REQ-023 DONE SHALL last one cycle:
- result_valid=1 and result = operand top;
- both stacks are cleared and err is cleared;
- the next state is ACCEPT.
REQ-024 Latency: result_valid SHALL be asserted N+1 cycles after '=' is accepted, where N is the number of operators pending at that point.
REQ-025 result SHALL hold its value between pulses.
REQ-026 The following SHALL set err and skip the push or pop:
- a push on a full stack (DEPTH entries);
- a reduction with fewer than 2 operands;
- ')' with no '(' present;
- '(' remaining at FINISH, which is popped without evaluation.
REQ-027 The FSM SHALL never deadlock on err; the expression still completes at '='.
REQ-028 If the operand stack is empty in DONE, result SHALL be 0.

Reset
REQ-029 SHALL, on rst high, immediately clear:
- state to ACCEPT;
- both stack pointers to 0;
- result, result_valid and err to 0.
REQ-030 While rst is high, SHALL drive in_ready to 0; in_ready is 1 in the first cycle after release.
REQ-031 rst asserted mid-expression SHALL discard all partial state with no result pulse.

Structure
REQ-032 SHALL place the following in shared package expr_pkg:
- token codes: digits 0-15, '(' 16, ')' 17, '*' 18, '+' 19, '-' 20, '=' 21;
- the state enum;
- the precedence function;
- the default DEPTH.
REQ-033 SHALL instantiate the existing ascii_to_decimal decoder as its one sub-module.
REQ-034 SHALL detect illegal characters separately, because the decoder maps them to 0.

Verification
REQ-035 SHALL cover: "3+4*2=" -> result_valid with result=11, err=0.
REQ-036 SHALL cover: "(3+4)*2=" -> result=14.
REQ-037 SHALL cover: "a-f=" -> result=32'hFFFFFFFB.
REQ-038 SHALL cover: "f*f*f*f*f*f*f*f=" -> result=2562890625, with in_ready low during each REDUCE.
REQ-039 SHALL cover: nine '(' then "1" ")))))))))" "=" with DEPTH=8 -> err=1 and completion without hang.
REQ-040 SHALL cover: rst pulsed after "5+", then "2=" -> result=2, err=0.
